data_memory_bank: RTL and testbench

Parametrised successor to the processor's data memory. It is a single-port word RAM with per-byte write enables and a registered (1-cycle) read with a valid flag. It adds an out-of-range address guard and a hardware clear engine that zeroes the whole array after a start pulse. It sits between the datapath load/store unit and the bus, and replaces the combinational-read memory.

---
 rtl/data_memory_bank_pkg.sv | 16 +
 rtl/data_memory_bank_if.sv | 33 +++
 rtl/data_memory_clear_fsm.sv | 63 ++++++
 rtl/data_memory_bank.sv | 97 +++++++++
 tb/tb_data_memory_bank.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_bank_pkg.sv
// Shared definitions for the data memory bank: byte width, clear
// engine state encoding and the lane-count helper.
package cpu_mem_pkg;

    localparam int BYTE = 8;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    function automatic int nb(input int b);
        return b / BYTE;
    endfunction

endpackage

// File: rtl/data_memory_bank_if.sv
// Load/store port of the data memory bank.
// master: wr_en, be, rd_en, addr, w_data, clr_start out; r_data, r_valid, addr_err, busy in.
interface data_memory_bank_if
    import cpu_mem_pkg::*;
#(
    parameter int B = 16,
    parameter int W = 11
) ();

    localparam int NB = nb(B);

    logic          wr_en;
    logic [NB-1:0] be;
    logic          rd_en;
    logic [W-1:0]  addr;
    logic [B-1:0]  w_data;
    logic [B-1:0]  r_data;
    logic          r_valid;
    logic          addr_err;
    logic          clr_start;
    logic          busy;

    modport master (
        output wr_en, be, rd_en, addr, w_data, clr_start,
        input  r_data, r_valid, addr_err, busy
    );

    modport slave (
        input  wr_en, be, rd_en, addr, w_data, clr_start,
        output r_data, r_valid, addr_err, busy
    );

endinterface

// File: rtl/data_memory_clear_fsm.sv
// Clear engine: sweeps every implemented word to zero after clr_start.
// Ports: clk, rst_n, clr_start in; busy, clr_we, clr_addr out.
module data_memory_clear_fsm
    import cpu_mem_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = 2**W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_start,
    output logic         busy,
    output logic         clr_we,
    output logic [W-1:0] clr_addr
);

    clr_state_t   state, state_d;
    logic [W-1:0] ptr, ptr_d;
    logic         last;

    // W+1 bits so that DEPTH = 2**W still has a representable end
    assign last = ({1'b0, ptr} == (W+1)'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        clr_we  = 1'b0;
        unique case (state)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end
            end
            CLR_RUN: begin
                clr_we = 1'b1;
                // pointer parks on the last word instead of wrapping
                if (last) begin
                    state_d = CLR_IDLE;
                end else begin
                    ptr_d = ptr + W'(1);
                end
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    assign busy     = (state == CLR_RUN);
    assign clr_addr = ptr;

endmodule

// File: rtl/data_memory_bank.sv
// Byte-lane word RAM with registered read, range guard and clear engine.
// Ports: clk, rst_n, bus (slave: request in; r_data/r_valid/addr_err/busy out).
module data_memory_bank
    import cpu_mem_pkg::*;
#(
    parameter int B     = 16,
    parameter int W     = 11,
    parameter int DEPTH = 2**W
) (
    input logic               clk,
    input logic               rst_n,
    data_memory_bank_if.slave bus
);

    localparam int NB = nb(B);

    logic         busy;
    logic         clr_we;
    logic [W-1:0] clr_addr;

    logic         acc;
    logic         in_range;
    logic         cpu_we;
    logic         rd_acc;
    logic [B-1:0] rd_word;

    logic [B-1:0] r_data_q;
    logic         r_valid_q;
    logic         addr_err_q;

    data_memory_clear_fsm #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (bus.clr_start),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign acc      = !busy && (bus.wr_en || bus.rd_en);
    assign in_range = ({1'b0, bus.addr} < (W+1)'(DEPTH));
    assign cpu_we   = !busy && bus.wr_en && in_range;
    assign rd_acc   = !busy && bus.rd_en;

    // One byte-wide RAM per lane; the clear engine owns the write
    // port while busy, so the CPU path is already gated off then.
    genvar i;
    generate
        for (i = 0; i < NB; i++) begin : g_lane
            logic [BYTE-1:0] mem [DEPTH];
            logic            we;
            logic            cpu_lane_we;
            logic [W-1:0]    wa;
            logic [BYTE-1:0] wd;
            logic [BYTE-1:0] cpu_byte;

            assign cpu_byte    = bus.w_data[i*BYTE +: BYTE];
            assign cpu_lane_we = cpu_we && bus.be[i];
            assign we          = clr_we || cpu_lane_we;
            assign wa          = clr_we ? clr_addr : bus.addr;
            assign wd          = clr_we ? '0 : cpu_byte;

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wa] <= wd;
                end
            end

            // write-first: a same-cycle write forwards its new byte
            assign rd_word[i*BYTE +: BYTE] =
                cpu_lane_we ? cpu_byte : mem[bus.addr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            r_valid_q  <= rd_acc;
            addr_err_q <= acc && !in_range;
            if (rd_acc) begin
                r_data_q <= in_range ? rd_word : '0;
            end
        end
    end

    assign bus.r_data   = r_data_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: vector table, clear-engine sequences and
// randomized traffic against a word-array reference model.
module tb_data_memory_bank;

    localparam int DA = 1000;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_bank_if #(.B(16), .W(10)) ifa ();
    data_memory_bank_if #(.B(16), .W(4))  ifb ();

    data_memory_bank #(.B(16), .W(10), .DEPTH(DA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    data_memory_bank #(.B(16), .W(4), .DEPTH(DB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int          sel = 0;
    logic        d_wr = 1'b0;
    logic        d_rd = 1'b0;
    logic        d_cs = 1'b0;
    logic [1:0]  d_be = '0;
    int          d_addr = 0;
    logic [15:0] d_data = '0;

    assign ifa.wr_en     = d_wr && (sel == 0);
    assign ifa.rd_en     = d_rd && (sel == 0);
    assign ifa.clr_start = d_cs && (sel == 0);
    assign ifa.be        = (sel == 0) ? d_be : 2'b00;
    assign ifa.addr      = 10'(d_addr);
    assign ifa.w_data    = d_data;

    assign ifb.wr_en     = d_wr && (sel == 1);
    assign ifb.rd_en     = d_rd && (sel == 1);
    assign ifb.clr_start = d_cs && (sel == 1);
    assign ifb.be        = (sel == 1) ? d_be : 2'b00;
    assign ifb.addr      = 4'(d_addr);
    assign ifb.w_data    = d_data;

    logic [15:0] o_d;
    logic        o_v, o_e, o_b;
    assign o_d = (sel == 0) ? ifa.r_data   : ifb.r_data;
    assign o_v = (sel == 0) ? ifa.r_valid  : ifb.r_valid;
    assign o_e = (sel == 0) ? ifa.addr_err : ifb.addr_err;
    assign o_b = (sel == 0) ? ifa.busy     : ifb.busy;

    // reference model: plain word arrays plus a countdown of sweep cycles
    logic [15:0] ref_mem [2][DA];
    bit          known   [2][DA];
    int          busy_m  [2];
    logic [15:0] exp_d   [2];
    bit          dk      [2];
    bit          exp_v, exp_e;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          w;
        logic [1:0]  b;
        bit          r;
        int          a;
        logic [15:0] d;
        logic [15:0] xd;
        bit          xv;
        bit          xe;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            busy_m[s] = 0;
            exp_d[s]  = '0;
            dk[s]     = 1'b1;
        end
    endtask

    task automatic step(input bit w, input logic [1:0] b, input bit r,
                        input int a, input logic [15:0] d, input bit c);
        int dep;
        bit idle, inr;
        dep  = (sel == 0) ? DA : DB;
        idle = (busy_m[sel] == 0);
        inr  = (a < dep);
        if (!idle) begin
            ref_mem[sel][dep - busy_m[sel]] = '0;
            known[sel][dep - busy_m[sel]]   = 1'b1;
            busy_m[sel]--;
        end else begin
            if (w && inr) begin
                for (int l = 0; l < 2; l++)
                    if (b[l]) ref_mem[sel][a][l*8 +: 8] = d[l*8 +: 8];
                if (b == 2'b11) known[sel][a] = 1'b1;
            end
            if (r) begin
                if (inr) begin
                    exp_d[sel] = ref_mem[sel][a];
                    dk[sel]    = known[sel][a];
                end else begin
                    exp_d[sel] = '0;
                    dk[sel]    = 1'b1;
                end
            end
            if (c) busy_m[sel] = dep;
        end
        exp_v = idle && r;
        exp_e = idle && (w || r) && !inr;
        d_wr = w; d_be = b; d_rd = r; d_addr = a; d_data = d; d_cs = c;
        @(posedge clk);
        #1;
        d_wr = 1'b0; d_rd = 1'b0; d_cs = 1'b0; d_be = 2'b00;
        chk("r_valid", 32'(o_v), 32'(exp_v));
        chk("addr_err", 32'(o_e), 32'(exp_e));
        chk("busy", 32'(o_b), 32'(busy_m[sel] != 0));
        if (dk[sel]) chk("r_data", 32'(o_d), 32'(exp_d[sel]));
    endtask

    task automatic count_sweep(output int cnt, input bit poke);
        cnt = 0;
        while (o_b && cnt < 2 * DA) begin
            step(poke, 2'b11, 1'b0, 3, 16'h1111, 1'b0);
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        model_reset();
        tbl[0]  = '{1, 2'b11, 0, 5,    16'hBEEF, 16'h0000, 0, 0};
        tbl[1]  = '{0, 2'b00, 1, 5,    16'h0000, 16'hBEEF, 1, 0};
        tbl[2]  = '{0, 2'b00, 0, 5,    16'h0000, 16'hBEEF, 0, 0};
        tbl[3]  = '{1, 2'b11, 0, 7,    16'h1234, 16'hBEEF, 0, 0};
        tbl[4]  = '{1, 2'b01, 0, 7,    16'hABCD, 16'hBEEF, 0, 0};
        tbl[5]  = '{0, 2'b00, 1, 7,    16'h0000, 16'h12CD, 1, 0};
        tbl[6]  = '{1, 2'b00, 0, 7,    16'hFFFF, 16'h12CD, 0, 0};
        tbl[7]  = '{0, 2'b00, 1, 7,    16'h0000, 16'h12CD, 1, 0};
        tbl[8]  = '{1, 2'b11, 0, 9,    16'h00FF, 16'h12CD, 0, 0};
        tbl[9]  = '{1, 2'b10, 1, 9,    16'h5A00, 16'h5AFF, 1, 0};
        tbl[10] = '{1, 2'b11, 0, 999,  16'h4321, 16'h5AFF, 0, 0};
        tbl[11] = '{1, 2'b11, 0, 1000, 16'h7777, 16'h5AFF, 0, 1};
        tbl[12] = '{0, 2'b00, 1, 1000, 16'h0000, 16'h0000, 1, 1};
        tbl[13] = '{0, 2'b00, 0, 0,    16'h0000, 16'h0000, 0, 0};
        tbl[14] = '{0, 2'b00, 1, 999,  16'h0000, 16'h4321, 1, 0};
        tbl[15] = '{1, 2'b11, 1, 1023, 16'h9999, 16'h0000, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata_a", 32'(ifa.r_data), 0);
        chk("rst_rvalid_a", 32'(ifa.r_valid), 0);
        chk("rst_err_a", 32'(ifa.addr_err), 0);
        chk("rst_busy_a", 32'(ifa.busy), 0);
        chk("rst_busy_b", 32'(ifb.busy), 0);
        #2 rst_n = 1'b1;

        sel = 0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].w, tbl[i].b, tbl[i].r, tbl[i].a, tbl[i].d, 1'b0);
            chk($sformatf("tbl%0d_rdata", i), 32'(o_d), 32'(tbl[i].xd));
            chk($sformatf("tbl%0d_rvalid", i), 32'(o_v), 32'(tbl[i].xv));
            chk($sformatf("tbl%0d_err", i), 32'(o_e), 32'(tbl[i].xe));
        end

        sel = 1;
        for (int i = 0; i < DB; i++)
            step(1'b1, 2'b11, 1'b0, i, 16'(i * 16'h0101 + 1), 1'b0);
        step(1'b0, 2'b00, 1'b0, 0, '0, 1'b1);
        count_sweep(cnt, 1'b1);
        chk("sweep_len", 32'(cnt), 32'(DB));
        for (int i = 0; i < DB; i++) begin
            step(1'b0, 2'b00, 1'b1, i, '0, 1'b0);
            chk("clr_word", 32'(o_d), 0);
        end

        for (int i = 0; i < DB; i++)
            step(1'b1, 2'b11, 1'b0, i, 16'hFFFF, 1'b0);
        step(1'b0, 2'b00, 1'b0, 0, '0, 1'b1);
        for (int k = 0; k < 6; k++)
            step(1'b0, 2'b00, 1'b0, 0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(ifb.busy), 0);
        chk("midrst_rvalid", 32'(ifb.r_valid), 0);
        chk("midrst_rdata", 32'(ifb.r_data), 0);
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < DB; i++) begin
            step(1'b0, 2'b00, 1'b1, i, '0, 1'b0);
            chk("midrst_word", 32'(o_d), (i < 6) ? 0 : 32'h0000FFFF);
        end
        step(1'b0, 2'b00, 1'b0, 0, '0, 1'b1);
        count_sweep(cnt, 1'b0);
        chk("sweep_len2", 32'(cnt), 32'(DB));
        for (int i = 0; i < DB; i++)
            step(1'b0, 2'b00, 1'b1, i, '0, 1'b0);

        sel = 0;
        step(1'b0, 2'b00, 1'b0, 0, '0, 1'b1);
        while (busy_m[0] != 0)
            step(1'b0, 2'b00, 1'b0, 0, '0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                            : int'($urandom_range(985, 1023));
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, 16'($urandom),
                 $urandom_range(0, 299) == 0);
        end
        while (busy_m[0] != 0)
            step(1'b0, 2'b00, 1'b1, 0, '0, 1'b0);

        sel = 1;
        for (int n = 0; n < 300; n++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 16'($urandom), $urandom_range(0, 39) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
